tdma_job_scheduler: RTL and testbench

- Shares one tensor-DMA frontend (5-D address generator plus burst issue) between NumReq requesters.
- Accepts job descriptors from each requester over a valid/ready handshake, arbitrates round-robin, and buffers granted jobs in a small FIFO.
- Launches one job at a time on the frontend with a single-cycle start pulse, waits for its finish, then reports completion with requester index and job ID.

---
 rtl/tdma_pkg.sv | 33 +++
 rtl/tdma_rr_arbiter.sv | 47 ++++
 rtl/tdma_job_scheduler.sv | 156 +++++++++++++++
 tb/tb_tdma_job_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdma_pkg.sv
// Shared types for the tensor-DMA job scheduler: job descriptor, FSM states
// and the zero-size job test.
package tdma_pkg;

  localparam int NumDims = 5;

  typedef struct packed {
    logic [63:0]                src_addr;
    logic [63:0]                dst_addr;
    logic [NumDims-1:1][31:0]   src_stride;
    logic [NumDims-1:1][31:0]   dst_stride;
    logic [NumDims-1:0][31:0]   shape;
  } tdma_job_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GUARD,
    BUSY,
    CPL
  } tdma_sched_state_e;

  // A job with any zero-length dimension moves no data and is never launched.
  function automatic logic tdma_job_is_empty(input tdma_job_t job);
    logic empty;
    empty = 1'b0;
    for (int k = 0; k < NumDims; k++) begin
      if (job.shape[k] == '0) empty = 1'b1;
    end
    return empty;
  endfunction

endpackage

// File: rtl/tdma_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that
// advances past each granted requester.
module tdma_rr_arbiter #(
  parameter int NumReq = 4,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              gnt_valid_o,
  output logic [IdxW-1:0]   gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int cand;
    logic [IdxW-1:0] cidx;
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    ptr_d       = ptr_q;
    cand        = 0;
    cidx        = '0;
    if (en_i) begin
      for (int i = 0; i < NumReq; i++) begin
        cand = int'(ptr_q) + i;
        if (cand >= NumReq) cand = cand - NumReq;
        cidx = IdxW'(cand);
        if (!gnt_valid_o && req_i[cidx]) begin
          gnt_valid_o = 1'b1;
          gnt_o[cidx] = 1'b1;
          gnt_idx_o   = cidx;
          ptr_d       = (cand == NumReq - 1) ? '0 : IdxW'(cand + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tdma_job_scheduler.sv
// Shares one tensor-DMA frontend between NumReq requesters: RR grant, job FIFO,
// launch/finish FSM, in-order completions. Optional stats via TDMA_SCHED_STATS_EN.
module tdma_job_scheduler
  import tdma_pkg::*;
#(
  parameter int NumReq     = 4,
  parameter int FifoDepth  = 4,
  parameter int JobIdWidth = 8,
  localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic      [NumReq-1:0]      req_valid_i,
  output logic      [NumReq-1:0]      req_ready_o,
  input  tdma_job_t [NumReq-1:0]      req_job_i,
  output logic                        start_new_transaction_o,
  output tdma_job_t                   job_o,
  input  logic                        transaction_finished_i,
  output logic                        cpl_valid_o,
  input  logic                        cpl_ready_i,
  output logic      [IdxW-1:0]        cpl_req_idx_o,
  output logic      [JobIdWidth-1:0]  cpl_job_id_o,
`ifdef TDMA_SCHED_STATS_EN
  input  logic                        stat_clr_i,
  output logic      [31:0]            stat_jobs_o,
  output logic      [31:0]            stat_busy_cycles_o,
`endif
  output logic                        busy_o
);

  localparam int AddrW = $clog2(FifoDepth);
  localparam logic [AddrW:0] PtrOne = 1;

  tdma_job_t             mem_job_q [FifoDepth];
  logic [IdxW-1:0]       mem_idx_q [FifoDepth];
  logic [JobIdWidth-1:0] mem_id_q  [FifoDepth];
  logic [AddrW:0]        wr_ptr_q, rd_ptr_q;
  logic [JobIdWidth-1:0] job_id_q;
  logic                  fifo_empty, fifo_full, push, pop;
  logic [IdxW-1:0]       gnt_idx;
  tdma_job_t             head_job;

  tdma_sched_state_e     state_q, state_d;
  tdma_job_t             act_job_q;
  logic [IdxW-1:0]       act_idx_q;
  logic [JobIdWidth-1:0] act_id_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign head_job   = mem_job_q[rd_ptr_q[AddrW-1:0]];

  // Grants depend only on FIFO space, never on the FSM state.
  tdma_rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_valid_i),
    .en_i        (rst_ni && !fifo_full),
    .gnt_o       (req_ready_o),
    .gnt_valid_o (push),
    .gnt_idx_o   (gnt_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      job_id_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
        job_id_q <= job_id_q + JobIdWidth'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_job_q[wr_ptr_q[AddrW-1:0]] <= req_job_i[gnt_idx];
      mem_idx_q[wr_ptr_q[AddrW-1:0]] <= gnt_idx;
      mem_id_q[wr_ptr_q[AddrW-1:0]]  <= job_id_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = tdma_job_is_empty(head_job) ? CPL : LAUNCH;
        end
      end
      LAUNCH: state_d = GUARD;
      // The finish level may still be high from the previous job here.
      GUARD:  state_d = BUSY;
      BUSY:   if (transaction_finished_i) state_d = CPL;
      CPL:    if (cpl_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      act_job_q <= '0;
      act_idx_q <= '0;
      act_id_q  <= '0;
    end else if (pop) begin
      act_job_q <= head_job;
      act_idx_q <= mem_idx_q[rd_ptr_q[AddrW-1:0]];
      act_id_q  <= mem_id_q[rd_ptr_q[AddrW-1:0]];
    end
  end

  assign start_new_transaction_o = (state_q == LAUNCH);
  assign job_o                   = act_job_q;
  assign cpl_valid_o             = (state_q == CPL);
  assign cpl_req_idx_o           = act_idx_q;
  assign cpl_job_id_o            = act_id_q;
  assign busy_o                  = (state_q != IDLE) || !fifo_empty;

`ifdef TDMA_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] stat_jobs_q, stat_busy_q;
  logic        in_flight;

  assign in_flight = (state_q == LAUNCH) || (state_q == GUARD) || (state_q == BUSY);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || stat_clr_i) begin
      stat_jobs_q <= '0;
      stat_busy_q <= '0;
    end else begin
      if (cpl_valid_o && cpl_ready_i) stat_jobs_q <= sat_inc(stat_jobs_q);
      if (in_flight)                  stat_busy_q <= sat_inc(stat_busy_q);
    end
  end

  assign stat_jobs_o        = stat_jobs_q;
  assign stat_busy_cycles_o = stat_busy_q;
`endif

endmodule

// File: tb/tb_tdma_job_scheduler.sv
// Bench for tdma_job_scheduler: directed vector table, reset/saturation
// sequences and randomized traffic against a job-level reference model.
module tb_tdma_job_scheduler;
  import tdma_pkg::*;

  localparam int NumReq = 4;
  localparam int FifoDepth = 4;
  localparam int JobIdWidth = 8;
  localparam int IdxW = 2;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic      [NumReq-1:0]     req_valid_i = '0;
  logic      [NumReq-1:0]     req_ready_o;
  tdma_job_t [NumReq-1:0]     req_job_i = '0;
  logic                       start_new_transaction_o;
  tdma_job_t                  job_o;
  logic                       transaction_finished_i = 1'b0;
  logic                       cpl_valid_o;
  logic                       cpl_ready_i = 1'b0;
  logic      [IdxW-1:0]       cpl_req_idx_o;
  logic      [JobIdWidth-1:0] cpl_job_id_o;
  logic                       busy_o;
`ifdef TDMA_SCHED_STATS_EN
  logic                       stat_clr_i = 1'b0;
  logic      [31:0]           stat_jobs_o;
  logic      [31:0]           stat_busy_cycles_o;
`endif

  tdma_job_scheduler #(
    .NumReq     (NumReq),
    .FifoDepth  (FifoDepth),
    .JobIdWidth (JobIdWidth)
  ) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .req_valid_i             (req_valid_i),
    .req_ready_o             (req_ready_o),
    .req_job_i               (req_job_i),
    .start_new_transaction_o (start_new_transaction_o),
    .job_o                   (job_o),
    .transaction_finished_i  (transaction_finished_i),
    .cpl_valid_o             (cpl_valid_o),
    .cpl_ready_i             (cpl_ready_i),
    .cpl_req_idx_o           (cpl_req_idx_o),
    .cpl_job_id_o            (cpl_job_id_o),
`ifdef TDMA_SCHED_STATS_EN
    .stat_clr_i              (stat_clr_i),
    .stat_jobs_o             (stat_jobs_o),
    .stat_busy_cycles_o      (stat_busy_cycles_o),
`endif
    .busy_o                  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_job(input string name, input tdma_job_t act, input tdma_job_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got src %0h shape0 %0h expected src %0h shape0 %0h",
                  name, act.src_addr, act.shape[0], exp.src_addr, exp.shape[0]);
  endtask

  function automatic tdma_job_t mk_job(input bit zero);
    tdma_job_t j;
    j.src_addr = {$urandom, $urandom};
    j.dst_addr = {$urandom, $urandom};
    for (int k = 1; k < NumDims; k++) begin
      j.src_stride[k] = $urandom;
      j.dst_stride[k] = $urandom;
    end
    for (int k = 0; k < NumDims; k++) j.shape[k] = 32'($urandom_range(1, 64));
    if (zero) j.shape[$urandom_range(0, NumDims - 1)] = '0;
    return j;
  endfunction

  function automatic bit moves_nothing(input tdma_job_t j);
    bit r = 0;
    for (int k = 0; k < NumDims; k++) if (j.shape[k] == 0) r = 1;
    return r;
  endfunction

  // Reference model: jobs flow grant -> queue -> active -> completion.
  typedef struct {
    int        idx;
    int        id;
    tdma_job_t job;
  } ent_t;

  ent_t      m_q[$];
  ent_t      m_cur;
  int        m_ptr, m_id, m_age;
  bit        m_active, m_cpl;
  longint    m_jobs, m_busyc;
  bit        pend[NumReq];
  tdma_job_t pjob[NumReq];
  int        dut_grants;

  task automatic model_init();
    m_q.delete();
    m_ptr = 0; m_id = 0; m_age = 0;
    m_active = 0; m_cpl = 0;
    m_jobs = 0; m_busyc = 0;
    for (int i = 0; i < NumReq; i++) pend[i] = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic model_cycle(input bit fin, input bit crdy, input bit clr);
    int g, c;
    logic [NumReq-1:0] exp_ready;
    for (int i = 0; i < NumReq; i++) begin
      req_valid_i[i] = pend[i];
      req_job_i[i]   = pjob[i];
    end
    transaction_finished_i = fin;
    cpl_ready_i = crdy;
`ifdef TDMA_SCHED_STATS_EN
    stat_clr_i = clr;
`endif
    @(negedge clk_i);
    g = -1;
    if (m_q.size() < FifoDepth) begin
      for (int k = 0; k < NumReq; k++) begin
        c = (m_ptr + k) % NumReq;
        if (pend[c] && g < 0) g = c;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    dut_grants += $countones(req_ready_o & req_valid_i);
    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    chk("start_pulse", 64'(start_new_transaction_o), 64'(m_active && m_age == 1));
    chk("cpl_valid", 64'(cpl_valid_o), 64'(m_cpl));
    chk("busy", 64'(busy_o), 64'(m_active || m_cpl || m_q.size() > 0));
    if (m_cpl) begin
      chk("cpl_idx", 64'(cpl_req_idx_o), 64'(m_cur.idx));
      chk("cpl_id", 64'(cpl_job_id_o), 64'(m_cur.id));
    end
    if (m_active || m_cpl) chk_job("job_o", job_o, m_cur.job);
`ifdef TDMA_SCHED_STATS_EN
    chk("stat_jobs", 64'(stat_jobs_o), 64'(m_jobs));
    chk("stat_busy", 64'(stat_busy_cycles_o), 64'(m_busyc));
`endif
    @(posedge clk_i);
    if (clr) begin
      m_jobs = 0; m_busyc = 0;
    end else begin
      if (m_cpl && crdy && m_jobs < 64'hFFFF_FFFF) m_jobs++;
      if (m_active && m_busyc < 64'hFFFF_FFFF) m_busyc++;
    end
    if (m_cpl) begin
      if (crdy) m_cpl = 0;
    end else if (m_active) begin
      if (m_age >= 3 && fin) begin
        m_active = 0; m_cpl = 1;
      end else m_age++;
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      if (moves_nothing(m_cur.job)) m_cpl = 1;
      else begin
        m_active = 1; m_age = 1;
      end
    end
    if (g >= 0) begin
      m_q.push_back('{g, m_id, pjob[g]});
      m_id = (m_id + 1) % (1 << JobIdWidth);
      m_ptr = (g + 1) % NumReq;
      pend[g] = 0;
    end
    #1;
  endtask

  // mode 0 random, 1 all valid + finish high, 2 all valid + frontend stalled,
  // 3 finish high with completion back-pressure
  task automatic run(input int mode, input int n);
    bit fin, crdy, clr;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < NumReq; i++) begin
        if (!pend[i]) begin
          case (mode)
            0: if ($urandom_range(0, 2) == 0) begin pend[i] = 1; pjob[i] = mk_job($urandom_range(0, 5) == 0); end
            1, 2: begin pend[i] = 1; pjob[i] = mk_job(0); end
            default: if ($urandom_range(0, 3) == 0) begin pend[i] = 1; pjob[i] = mk_job(0); end
          endcase
        end
      end
      case (mode)
        0: begin fin = ($urandom_range(0, 2) == 0); crdy = $urandom_range(0, 1) == 1; clr = ($urandom_range(0, 15) == 0); end
        1: begin fin = 1; crdy = 1; clr = 0; end
        2: begin fin = 0; crdy = 1; clr = 0; end
        default: begin fin = 1; crdy = (cyc % 5 == 4); clr = crdy; end
      endcase
      model_cycle(fin, crdy, clr);
    end
  endtask

  task automatic reset_dut(input bit check);
    rst_ni = 1'b0;
    req_valid_i = '0;
    transaction_finished_i = 1'b0;
    cpl_ready_i = 1'b0;
`ifdef TDMA_SCHED_STATS_EN
    stat_clr_i = 1'b0;
`endif
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_init();
    if (check) begin
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_start", 64'(start_new_transaction_o), 64'd0);
      chk("rst_cpl_valid", 64'(cpl_valid_o), 64'd0);
      chk("rst_cpl_idx", 64'(cpl_req_idx_o), 64'd0);
      chk("rst_cpl_id", 64'(cpl_job_id_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk_job("rst_job_o", job_o, '0);
`ifdef TDMA_SCHED_STATS_EN
      chk("rst_stat_jobs", 64'(stat_jobs_o), 64'd0);
      chk("rst_stat_busy", 64'(stat_busy_cycles_o), 64'd0);
`endif
    end
  endtask

  typedef struct {
    logic [NumReq-1:0] valid;
    bit                zero;
    bit                fin;
    bit                crdy;
    logic [NumReq-1:0] e_ready;
    bit                e_start;
    bit                e_cpl;
    bit                e_busy;
    int                e_idx;
    int                e_id;
  } vec_t;

  vec_t vecs[$];

  initial begin
    tdma_job_t tjob;
    // single job from req0 with shape {16,2,1,1,1}, then a zero-shape job from req2
    vecs.push_back('{4'b0001, 0, 0, 1, 4'b0001, 0, 0, 0, 0, 0});
    vecs.push_back('{4'b0000, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 0});
    vecs.push_back('{4'b0000, 0, 0, 1, 4'b0000, 1, 0, 1, 0, 0});
    vecs.push_back('{4'b0000, 0, 1, 1, 4'b0000, 0, 0, 1, 0, 0});
    vecs.push_back('{4'b0000, 0, 1, 1, 4'b0000, 0, 0, 1, 0, 0});
    vecs.push_back('{4'b0000, 0, 0, 1, 4'b0000, 0, 1, 1, 0, 0});
    vecs.push_back('{4'b0100, 1, 0, 1, 4'b0100, 0, 0, 0, 0, 0});
    vecs.push_back('{4'b0000, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 0});
    vecs.push_back('{4'b0000, 0, 0, 0, 4'b0000, 0, 1, 1, 2, 1});
    vecs.push_back('{4'b0000, 0, 0, 1, 4'b0000, 0, 1, 1, 2, 1});
    vecs.push_back('{4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0});

    model_init();
    dut_grants = 0;
    reset_dut(1);

    tjob = '0;
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].valid != '0) begin
        tjob = mk_job(vecs[v].zero);
        if (!vecs[v].zero) begin
          tjob.shape[0] = 32'd16;
          tjob.shape[1] = 32'd2;
          for (int k = 2; k < NumDims; k++) tjob.shape[k] = 32'd1;
        end
      end
      req_valid_i = vecs[v].valid;
      for (int i = 0; i < NumReq; i++) req_job_i[i] = tjob;
      transaction_finished_i = vecs[v].fin;
      cpl_ready_i = vecs[v].crdy;
      @(negedge clk_i);
      chk($sformatf("vec%0d_ready", v), 64'(req_ready_o), 64'(vecs[v].e_ready));
      chk($sformatf("vec%0d_start", v), 64'(start_new_transaction_o), 64'(vecs[v].e_start));
      chk($sformatf("vec%0d_cpl", v), 64'(cpl_valid_o), 64'(vecs[v].e_cpl));
      chk($sformatf("vec%0d_busy", v), 64'(busy_o), 64'(vecs[v].e_busy));
      if (vecs[v].e_cpl) begin
        chk($sformatf("vec%0d_idx", v), 64'(cpl_req_idx_o), 64'(vecs[v].e_idx));
        chk($sformatf("vec%0d_id", v), 64'(cpl_job_id_o), 64'(vecs[v].e_id));
        chk_job($sformatf("vec%0d_job", v), job_o, tjob);
      end
      @(posedge clk_i);
      #1;
    end

    // continuous traffic on all requesters: RR order and IDs checked by the model
    reset_dut(0);
    run(1, 30);

    // frontend stalled: 1 active + FifoDepth queued, then reset mid-BUSY
    reset_dut(0);
    dut_grants = 0;
    run(2, 12);
    chk("sat_accepted", 64'(dut_grants), 64'(FifoDepth + 1));
    reset_dut(1);
    run(1, 12);

    // stale finish level with completion back-pressure
    run(3, 40);

    run(0, 2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
